// File: rtl/bcd_7seg_scan.sv
// Captures three BCD digits on the converter's done strobe and scans them onto a
// common-anode 7-segment display (active-low segments/anodes) with a 1-cycle gap per digit.
module bcd_7seg_scan #(
  parameter int N_DIG       = 3,
  parameter int AN_W        = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            done,
  input  logic [3:0]      BCD [N_DIG],
  input  logic            en,
  output logic [6:0]      seg,
  output logic [AN_W-1:0] an,
  output logic            loaded
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  typedef enum logic [1:0] {BLANK, SHOW, GAP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [3:0]        digit [N_DIG];
  logic              tick;
  logic              lit;
  logic              zero_above;
  logic [N_DIG-1:0]  blank_lz;
  logic [6:0]        seg_n;
  logic [AN_W-1:0]   an_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign tick = (cnt == CW'(REFRESH_DIV - 1));

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    blank_lz   = '0;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < N_DIG - 1; k++) begin
      zero_above                = zero_above && (digit[N_DIG-1-k] == 4'd0);
      blank_lz[N_DIG-1-k]       = BLANK_LZ && zero_above;
    end
  end

  // The divider is held during GAP so each SHOW lasts exactly REFRESH_DIV cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    if (!en) begin
      state_n = BLANK;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      unique case (state)
        BLANK, SHOW: begin
          cnt_n = tick ? '0 : cnt + 1'b1;
          if (tick) state_n = (state == BLANK) ? SHOW : GAP;
        end
        GAP: begin
          state_n = SHOW;
          idx_n   = (idx == IW'(N_DIG - 1)) ? '0 : idx + 1'b1;
        end
        default: state_n = BLANK;
      endcase
    end
  end

  // Outputs are registered from the state being entered, but with the digits held
  // before this edge, so a digit captured on the same edge appears one cycle later.
  always_comb begin
    lit   = en && loaded && (state_n == SHOW) && !blank_lz[idx_n];
    an_n  = '1;
    seg_n = 7'h7F;
    if (lit) begin
      an_n[idx_n] = 1'b0;
      seg_n       = decode(digit[idx_n]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BLANK;
      cnt    <= '0;
      idx    <= '0;
      loaded <= 1'b0;
      seg    <= 7'h7F;
      an     <= '1;
      for (int unsigned i = 0; i < N_DIG; i++) digit[i] <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      seg   <= seg_n;
      an    <= an_n;
      if (done) begin
        loaded <= 1'b1;
        for (int unsigned i = 0; i < N_DIG; i++) digit[i] <= BCD[i];
      end
    end
  end

endmodule
